// File: rtl/ssp_pkg.sv
// ssp_pkg: shared constants and types for the SSP transmit arbiter.
// No ports. Holds the FSM state codes, default sizing and byte type.
package ssp_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef logic [BYTE_W-1:0] byte_t;

    // Index width for an n-entry vector, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssp_tx_arbiter_if.sv
// ssp_tx_arbiter_if: producer/TX-FIFO side bundle of the arbiter.
// Ports (as signals): REQ/LAST/REQ_DATA and TXFIFO_FULL from the
// environment; ACK/GNT/BUSY and TXFIFO_WRITE/TXFIFO_WDATA from the
// arbiter. 'master' is the environment view, 'slave' the arbiter view.
interface ssp_tx_arbiter_if
    import ssp_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) ();

    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ-1:0]        LAST;
    logic [BYTE_W*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]        ACK;
    logic [NUM_REQ-1:0]        GNT;
    logic                      TXFIFO_FULL;
    logic                      TXFIFO_WRITE;
    byte_t                     TXFIFO_WDATA;
    logic                      BUSY;

    modport master (
        output REQ, LAST, REQ_DATA, TXFIFO_FULL,
        input  ACK, GNT, TXFIFO_WRITE, TXFIFO_WDATA, BUSY
    );

    modport slave (
        input  REQ, LAST, REQ_DATA, TXFIFO_FULL,
        output ACK, GNT, TXFIFO_WRITE, TXFIFO_WDATA, BUSY
    );

endinterface

// File: rtl/ssp_rr_pick.sv
// ssp_rr_pick: combinational round-robin picker.
// Ports: req (request vector), ptr (last winner); win (one-hot),
// win_idx (binary index), any (some request present). The search
// starts at ptr+1 and wraps, so the last winner has lowest priority.
module ssp_rr_pick
    import ssp_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    int          j;
    logic [IW-1:0] jj;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        jj      = '0;
        for (int i = 1; i <= N; i++) begin
            j  = (int'(ptr) + i) % N;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                win[jj] = 1'b1;
                win_idx = jj;
            end
        end
    end

endmodule

// File: rtl/ssp_tx_arbiter.sv
// ssp_tx_arbiter: shares the SSP TX FIFO write port among NUM_REQ
// byte producers with round-robin grants and a per-grant burst cap.
// Ports: PCLK (clock), CLEAR (async active-high reset), bus (slave
// view: REQ/LAST/REQ_DATA/TXFIFO_FULL in; ACK/GNT/BUSY and the TX FIFO
// write strobe/data out). ACK/TXFIFO_* are combinational, the rest
// registered.
module ssp_tx_arbiter
    import ssp_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic              PCLK,
    input logic              CLEAR,
    ssp_tx_arbiter_if.slave  bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    // Pointer resets to the top index so requester 0 wins first.
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] pick_win;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0][BYTE_W-1:0] data_arr;

    logic               req_g;
    logic               last_g;
    byte_t              data_g;
    logic               accept;
    logic [CW-1:0]      cnt_inc;

    ssp_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req     (bus.REQ),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign data_arr = bus.REQ_DATA;

    always_comb begin
        req_g   = bus.REQ[gidx_q];
        last_g  = bus.LAST[gidx_q];
        data_g  = data_arr[gidx_q];
        accept  = (state_q == ST_XFER) && req_g && !bus.TXFIFO_FULL;
        cnt_inc = cnt_q + CW'(1);
    end

    // gnt_q is one-hot on the granted index while in XFER, so it
    // doubles as the ACK pattern.
    assign bus.ACK          = accept ? gnt_q : '0;
    assign bus.TXFIFO_WRITE = accept;
    assign bus.TXFIFO_WDATA = accept ? data_g : '0;
    assign bus.GNT          = gnt_q;
    assign bus.BUSY         = busy_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_XFER;
                    gnt_d   = pick_win;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_XFER: begin
                if (!req_g) begin
                    // Producer withdrew: release without writing.
                    state_d = ST_GAP;
                    gnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                    if (last_g || (cnt_inc == CNT_MAX)) begin
                        state_d = ST_GAP;
                        gnt_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                // Pointer moves only now, so the next pick skips g.
                state_d = ST_IDLE;
                ptr_d   = gidx_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// tb_ssp_tx_arbiter: directed and randomized checks of ssp_tx_arbiter
// against a message-level round-robin model kept in the bench.
module tb_ssp_tx_arbiter;
    import ssp_pkg::*;

    localparam int NR = 4;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ssp_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    ssp_tx_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .PCLK  (clk),
        .CLEAR (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  q_data [NR][$];
    bit          q_last [NR][$];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [7:0] d, input logic l);
        bus.REQ[i]            = v;
        bus.REQ_DATA[8*i +: 8] = d;
        bus.LAST[i]           = l;
    endtask

    task automatic idle_bus();
        bus.REQ         = '0;
        bus.LAST        = '0;
        bus.REQ_DATA    = '0;
        bus.TXFIFO_FULL = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst = 1'b1;
        @(negedge clk);
        to_pos();
        rst = 1'b0;
    endtask

    // Message-level model: winner is the first requester with bytes
    // left after the previous winner; it sends until LAST, MB bytes
    // or its queue runs dry.
    task automatic build_expected();
        logic [7:0] md [NR][$];
        bit         ml [NR][$];
        int ptr, w, n, j;
        bit lst;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            md[i] = q_data[i];
            ml[i] = q_last[i];
        end
        ptr = NR - 1;
        forever begin
            w = -1;
            for (int s = 1; s <= NR; s++) begin
                j = (ptr + s) % NR;
                if (w < 0 && md[j].size() > 0) w = j;
            end
            if (w < 0) break;
            n   = 0;
            lst = 1'b0;
            while (md[w].size() > 0 && n < MB && !lst) begin
                exp_q.push_back({8'(w), md[w].pop_front()});
                lst = ml[w].pop_front();
                n++;
            end
            ptr = w;
        end
    endtask

    task automatic run_engine(input bit rand_full, input int budget);
        int k, cyc, idx;
        bit done, empty;
        k = 0;
        cyc = 0;
        done = 1'b0;
        obs_q.delete();
        while (!done) begin
            for (int i = 0; i < NR; i++) begin
                if (q_data[i].size() > 0)
                    set_req(i, 1'b1, q_data[i][0], q_last[i][0]);
                else
                    set_req(i, 1'b0, 8'h00, 1'b0);
            end
            bus.TXFIFO_FULL = rand_full && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk("eng_onehot", 32'($onehot0(bus.GNT)), 32'd1);
            chk("eng_ack", 32'(bus.ACK),
                bus.TXFIFO_WRITE ? 32'(bus.GNT) : 32'd0);
            if (bus.TXFIFO_FULL)
                chk("eng_full", 32'(bus.TXFIFO_WRITE), 32'd0);
            if (bus.TXFIFO_WRITE) begin
                idx = 0;
                for (int i = 0; i < NR; i++)
                    if (bus.ACK[i]) idx = i;
                obs_q.push_back({8'(idx), bus.TXFIFO_WDATA});
                if (k < exp_q.size())
                    chk("eng_seq", 32'({8'(idx), bus.TXFIFO_WDATA}),
                        32'(exp_q[k]));
                else
                    chk("eng_extra", 32'(k), 32'(exp_q.size()));
                k++;
                if (q_data[idx].size() > 0) begin
                    void'(q_data[idx].pop_front());
                    void'(q_last[idx].pop_front());
                end
            end
            to_pos();
            cyc++;
            empty = 1'b1;
            for (int i = 0; i < NR; i++)
                if (q_data[i].size() > 0) empty = 1'b0;
            if (empty && k >= exp_q.size() && !bus.BUSY) begin
                done = 1'b1;
            end else if (cyc >= budget) begin
                chk("eng_timeout", 32'(cyc), 32'(budget + 1));
                done = 1'b1;
            end
        end
        chk("eng_count", 32'(k), 32'(exp_q.size()));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] want;
        int k, cyc, last_w, er, nm, len;

        // Reset state, with a request already pending.
        idle_bus();
        set_req(0, 1'b1, 8'h99, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(bus.GNT), 32'd0);
        chk("rst_ack", 32'(bus.ACK), 32'd0);
        chk("rst_wr", 32'(bus.TXFIFO_WRITE), 32'd0);
        chk("rst_wdata", 32'(bus.TXFIFO_WDATA), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);

        // Single requester, two-byte message.
        do_reset();
        set_req(2, 1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        chk("s1_gnt_idle", 32'(bus.GNT), 32'd0);
        to_pos();
        @(negedge clk);
        chk("s1_gnt", 32'(bus.GNT), 32'h4);
        chk("s1_wr0", 32'(bus.TXFIFO_WRITE), 32'd1);
        chk("s1_d0", 32'(bus.TXFIFO_WDATA), 32'hA5);
        chk("s1_ack0", 32'(bus.ACK), 32'h4);
        to_pos();
        set_req(2, 1'b1, 8'h3C, 1'b1);
        @(negedge clk);
        chk("s1_wr1", 32'(bus.TXFIFO_WRITE), 32'd1);
        chk("s1_d1", 32'(bus.TXFIFO_WDATA), 32'h3C);
        chk("s1_ack1", 32'(bus.ACK), 32'h4);
        to_pos();
        set_req(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("s1_gap_gnt", 32'(bus.GNT), 32'd0);
        chk("s1_gap_busy", 32'(bus.BUSY), 32'd1);
        chk("s1_gap_wr", 32'(bus.TXFIFO_WRITE), 32'd0);
        to_pos();
        @(negedge clk);
        chk("s1_idle_busy", 32'(bus.BUSY), 32'd0);

        // Round robin with all four holding one-byte messages.
        do_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        k = 0;
        cyc = 0;
        last_w = 0;
        while (k < 5 && cyc < 40) begin
            @(negedge clk);
            if (bus.TXFIFO_WRITE) begin
                er = k % NR;
                chk("rr_ack", 32'(bus.ACK), 32'(1 << er));
                chk("rr_data", 32'(bus.TXFIFO_WDATA), 32'(8'h10 + er));
                if (k > 0) chk("rr_spacing", 32'(cyc - last_w), 32'd3);
                last_w = cyc;
                k++;
            end
            to_pos();
            cyc++;
            if (k == 5) idle_bus();
        end
        chk("rr_count", 32'(k), 32'd5);

        // Burst cap: requester 1 streams 20 bytes, requester 3 eight.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
        for (int n = 0; n < 20; n++) begin
            q_data[1].push_back(8'(n));
            q_last[1].push_back(1'b0);
        end
        for (int n = 0; n < 8; n++) begin
            q_data[3].push_back(8'(8'hC0 + n));
            q_last[3].push_back(1'b0);
        end
        build_expected();
        run_engine(1'b0, 400);
        chk("bl_len", 32'(obs_q.size() >= 24), 32'd1);
        for (int n = 0; n < 24; n++) begin
            if (n < 8)       want = {8'd1, 8'(n)};
            else if (n < 16) want = {8'd3, 8'(8'hC0 + n - 8)};
            else             want = {8'd1, 8'(n - 8)};
            if (n < obs_q.size())
                chk("bl_seq", 32'(obs_q[n]), 32'(want));
        end

        // FIFO full stall on byte 7E of an 8-byte burst.
        do_reset();
        set_req(0, 1'b1, 8'h20, 1'b0);
        @(negedge clk);
        to_pos();
        for (int n = 0; n < 8; n++) begin
            b = (n == 1) ? 8'h7E : 8'(8'h20 + n);
            set_req(0, 1'b1, b, 1'b0);
            if (n == 1) begin
                bus.TXFIFO_FULL = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("st_gnt", 32'(bus.GNT), 32'h1);
                    chk("st_ack", 32'(bus.ACK), 32'd0);
                    chk("st_wr", 32'(bus.TXFIFO_WRITE), 32'd0);
                    to_pos();
                end
                bus.TXFIFO_FULL = 1'b0;
            end
            @(negedge clk);
            chk("st_wr_ok", 32'(bus.TXFIFO_WRITE), 32'd1);
            chk("st_data", 32'(bus.TXFIFO_WDATA), 32'(b));
            chk("st_ack_ok", 32'(bus.ACK), 32'h1);
            to_pos();
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("st_rel_gnt", 32'(bus.GNT), 32'd0);
        chk("st_rel_busy", 32'(bus.BUSY), 32'd1);

        // Requester 1 drops after two bytes; 2 must beat 0 next.
        do_reset();
        set_req(1, 1'b1, 8'h41, 1'b0);
        set_req(2, 1'b1, 8'h51, 1'b1);
        @(negedge clk);
        to_pos();
        @(negedge clk);
        chk("dr_d0", 32'(bus.TXFIFO_WDATA), 32'h41);
        chk("dr_ack0", 32'(bus.ACK), 32'h2);
        to_pos();
        set_req(1, 1'b1, 8'h42, 1'b0);
        @(negedge clk);
        chk("dr_d1", 32'(bus.TXFIFO_WDATA), 32'h42);
        to_pos();
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h01, 1'b1);
        @(negedge clk);
        chk("dr_nowr", 32'(bus.TXFIFO_WRITE), 32'd0);
        chk("dr_gnt_held", 32'(bus.GNT), 32'h2);
        to_pos();
        @(negedge clk);
        chk("dr_gap_gnt", 32'(bus.GNT), 32'd0);
        chk("dr_gap_busy", 32'(bus.BUSY), 32'd1);
        to_pos();
        @(negedge clk);
        chk("dr_idle_gnt", 32'(bus.GNT), 32'd0);
        to_pos();
        @(negedge clk);
        chk("dr_next_gnt", 32'(bus.GNT), 32'h4);
        chk("dr_next_d", 32'(bus.TXFIFO_WDATA), 32'h51);

        // Asynchronous reset while requester 2 offers byte 3 of 5.
        do_reset();
        set_req(2, 1'b1, 8'hD0, 1'b0);
        @(negedge clk);
        to_pos();
        @(negedge clk);
        chk("rm_d0", 32'(bus.TXFIFO_WDATA), 32'hD0);
        to_pos();
        set_req(2, 1'b1, 8'hD1, 1'b0);
        @(negedge clk);
        chk("rm_d1", 32'(bus.TXFIFO_WDATA), 32'hD1);
        to_pos();
        set_req(2, 1'b1, 8'hD2, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("rm_gnt", 32'(bus.GNT), 32'd0);
        chk("rm_ack", 32'(bus.ACK), 32'd0);
        chk("rm_wr", 32'(bus.TXFIFO_WRITE), 32'd0);
        chk("rm_wdata", 32'(bus.TXFIFO_WDATA), 32'd0);
        chk("rm_busy", 32'(bus.BUSY), 32'd0);
        #1;
        rst = 1'b0;
        set_req(0, 1'b1, 8'hE0, 1'b1);
        @(negedge clk);
        chk("rm_idle", 32'(bus.GNT), 32'd0);
        to_pos();
        @(negedge clk);
        chk("rm_win0", 32'(bus.GNT), 32'h1);
        chk("rm_e0", 32'(bus.TXFIFO_WDATA), 32'hE0);
        to_pos();
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rm_gap", 32'(bus.GNT), 32'd0);
        to_pos();
        @(negedge clk);
        to_pos();
        @(negedge clk);
        chk("rm_regnt", 32'(bus.GNT), 32'h4);
        chk("rm_resend", 32'(bus.TXFIFO_WDATA), 32'hD2);
        chk("rm_resend_wr", 32'(bus.TXFIFO_WRITE), 32'd1);

        // Random messages with random FIFO back-pressure.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                q_data[i].delete();
                q_last[i].delete();
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 12);
                    for (int n = 0; n < len; n++) begin
                        q_data[i].push_back(8'($urandom));
                        q_last[i].push_back(n == len - 1);
                    end
                end
            end
            build_expected();
            run_engine(1'b1, 3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
